// File: rtl/ros2_pub_sched.sv
// Round-robin arbiter in front of the single ros2_ether publisher app-data
// port. A pending source is picked in IDLE and its payload is snapshotted.
// The scheduler then runs req/grant, holds the bus, pulses rel with the
// source's ack, and waits out the minimum publication interval.
module ros2_pub_sched #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_BYTES   = 64,
    parameter int HOLD_CYCLES  = 4,
    parameter int MIN_INTERVAL = 125000
) (
    input  logic                            clk_int,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*DATA_BYTES*8-1:0] src_data,
    input  logic [NUM_SRC*8-1:0]            src_len,
    output logic [NUM_SRC-1:0]              src_ack,
    output logic [DATA_BYTES*8-1:0]         pub_app_data,
    output logic [7:0]                      pub_app_data_len,
    output logic                            pub_app_data_req,
    input  logic                            pub_app_data_grant,
    output logic                            pub_app_data_rel,
    output logic                            busy,
    output logic [$clog2(NUM_SRC)-1:0]      cur_src
);

    localparam int DW = DATA_BYTES * 8;
    localparam int SW = $clog2(NUM_SRC);
    localparam int GW = (MIN_INTERVAL > 2) ? $clog2(MIN_INTERVAL) : 1;
    // The interval counter is loaded on REL entry, so it already covers the
    // REL cycle. REL -> IDLE -> REQ is two cycles on its own, so intervals of
    // 2 or less need no GAP state.
    localparam logic [GW-1:0] GAP_LOAD  = (MIN_INTERVAL > 2) ? GW'(MIN_INTERVAL - 1) : '0;
    localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam logic [7:0]    LEN_MAX   = 8'(DATA_BYTES);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, REL, GAP} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   rr_ptr_reg;
    logic [SW-1:0]   cur_src_reg;
    logic [7:0]      hold_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic [DW-1:0]   data_reg;
    logic [7:0]      len_reg;

    logic [DW-1:0]   data_arr [NUM_SRC];
    logic [7:0]      len_arr  [NUM_SRC];
    logic [SW-1:0]   sel_idx;
    logic            sel_found;
    logic [SW:0]     idx_w;
    logic [7:0]      sel_len;

    // Unpack the flat source buses and decode the per-source ack pulse
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign data_arr[gi] = src_data[gi*DW +: DW];
            assign len_arr[gi]  = src_len[gi*8 +: 8];
            assign src_ack[gi]  = (state_reg == REL) && (cur_src_reg == SW'(gi));
        end
    endgenerate

    // Round-robin pick: first pending source strictly after the pointer, with wrap
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        idx_w     = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx_w = {1'b0, rr_ptr_reg} + (SW+1)'(k);
            if (idx_w >= (SW+1)'(NUM_SRC)) begin
                idx_w = idx_w - (SW+1)'(NUM_SRC);
            end
            if (!sel_found && src_valid[idx_w[SW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx_w[SW-1:0];
            end
        end
    end

    // Oversized lengths are clamped to the bus width; zero passes through
    always_comb begin
        sel_len = len_arr[sel_idx];
        if (len_arr[sel_idx] > LEN_MAX) begin
            sel_len = LEN_MAX;
        end
    end

    // FSM state register
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_next       = state_reg;
        pub_app_data_req = 1'b0;
        pub_app_data_rel = 1'b0;
        busy             = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                pub_app_data_req = 1'b1;
                if (pub_app_data_grant) begin
                    state_next = (HOLD_CYCLES == 0) ? REL : HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_reg <= 8'd1) begin
                    state_next = REL;
                end
            end
            REL: begin
                pub_app_data_rel = 1'b1;
                state_next       = (MIN_INTERVAL > 2) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt_reg <= GW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Snapshot the winning source's payload at selection; it stays put until the next pick
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            len_reg     <= '0;
            cur_src_reg <= '0;
        end else if (state_reg == IDLE && sel_found) begin
            data_reg    <= data_arr[sel_idx];
            len_reg     <= sel_len;
            cur_src_reg <= sel_idx;
        end
    end

    // Hold and interval counters plus the round-robin pointer
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            rr_ptr_reg   <= SW'(NUM_SRC - 1);
        end else begin
            if (state_reg == REQ && pub_app_data_grant) begin
                hold_cnt_reg <= HOLD_LOAD;
            end else if (state_reg == HOLD && hold_cnt_reg != 8'd0) begin
                hold_cnt_reg <= hold_cnt_reg - 8'd1;
            end

            if (state_next == REL && state_reg != REL) begin
                gap_cnt_reg <= GAP_LOAD;
            end else if ((state_reg == REL || state_reg == GAP) && gap_cnt_reg != '0) begin
                gap_cnt_reg <= gap_cnt_reg - GW'(1);
            end

            if (state_reg == REL) begin
                rr_ptr_reg <= cur_src_reg;
            end
        end
    end

    assign pub_app_data     = data_reg;
    assign pub_app_data_len = len_reg;
    assign cur_src          = cur_src_reg;

endmodule

// File: tb/tb_ros2_pub_sched.sv
// Scoreboard bench for ros2_pub_sched: staged messages push their expected
// publication, and every rel pulse pops and compares source, length, payload
// and ack. A single process drives the stimulus, the grant responder and the
// monitor, all on the falling edge.
module tb_ros2_pub_sched;

    localparam int NS   = 4;
    localparam int DB   = 64;
    localparam int DW   = DB * 8;
    localparam int HOLD = 4;
    localparam int MI   = 10;

    typedef struct {
        int           src;
        int           len;
        logic [DW-1:0] data;
    } exp_t;

    logic                clk_int = 1'b0;
    logic                rst_n;
    logic [NS-1:0]       src_valid;
    logic [NS*DW-1:0]    src_data;
    logic [NS*8-1:0]     src_len;
    logic [NS-1:0]       src_ack;
    logic [DW-1:0]       pub_app_data;
    logic [7:0]          pub_app_data_len;
    logic                pub_app_data_req;
    logic                pub_app_data_grant;
    logic                pub_app_data_rel;
    logic                busy;
    logic [1:0]          cur_src;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_count = 0;
    int   last_rel_cyc = 0;
    bit   have_rel = 0;
    bit   spacing_chk = 0;
    bit   req_prev = 0;
    bit   grant_en = 1;
    int   grant_delay = 3;
    int   gcnt = 0;

    ros2_pub_sched #(
        .NUM_SRC(NS), .DATA_BYTES(DB), .HOLD_CYCLES(HOLD), .MIN_INTERVAL(MI)
    ) dut (
        .clk_int(clk_int), .rst_n(rst_n),
        .src_valid(src_valid), .src_data(src_data), .src_len(src_len),
        .src_ack(src_ack),
        .pub_app_data(pub_app_data), .pub_app_data_len(pub_app_data_len),
        .pub_app_data_req(pub_app_data_req), .pub_app_data_grant(pub_app_data_grant),
        .pub_app_data_rel(pub_app_data_rel),
        .busy(busy), .cur_src(cur_src)
    );

    always #5 clk_int = ~clk_int;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Compare each rel pulse against the scoreboard head; track req/rel spacing
    task automatic mon_step();
        exp_t e;
        if (!rst_n) begin
            req_prev = 0;
            return;
        end
        if (pub_app_data_rel) begin
            chk_val("req_at_rel", pub_app_data_req, 0);
            chk_val("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk_val("rel_src", cur_src, e.src);
                chk_val("rel_len", pub_app_data_len, e.len);
                chk_val("rel_data", pub_app_data, e.data);
                chk_val("rel_ack", src_ack, NS'(1) << e.src);
            end
            $display("PUB src=%0d len=%0d ack=%b cyc=%0d", cur_src, pub_app_data_len, src_ack, cyc);
            rel_count++;
            last_rel_cyc = cyc;
            have_rel = 1;
        end
        if (pub_app_data_req && !req_prev && spacing_chk && have_rel)
            chk_val("rel_to_req", cyc - last_rel_cyc, MI);
        req_prev = pub_app_data_req;
    endtask

    // ros2_ether stand-in: return grant grant_delay cycles after req is seen
    task automatic grant_step();
        if (grant_en) begin
            if (pub_app_data_req && !pub_app_data_grant) begin
                gcnt++;
                if (gcnt == grant_delay) pub_app_data_grant = 1'b1;
            end else if (pub_app_data_grant) begin
                pub_app_data_grant = 1'b0;
                gcnt = 0;
            end
        end else begin
            gcnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk_int);
        cyc++;
        mon_step();
        grant_step();
    endtask

    task automatic stage(input int s, input int len, input int exp_len);
        exp_t e;
        e.src  = s;
        e.len  = exp_len;
        e.data = rand_data();
        src_data[s*DW +: DW] = e.data;
        src_len[s*8 +: 8]    = 8'(len);
        src_valid[s]         = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk_val("idle_reached", busy, 0);
    endtask

    task automatic wait_rel();
        int n = 0;
        while (!pub_app_data_rel && n < 100) begin tick(); n++; end
        chk_val("rel_seen", pub_app_data_rel, 1);
    endtask

    // One isolated publication from an idle scheduler, with timing checks
    task automatic run_handshake(input bit corrupt);
        int n;
        int s;
        n = 0;
        while (!pub_app_data_req && n < 20) begin tick(); n++; end
        chk_val("req_latency", n, 1);
        chk_val("len_at_req", pub_app_data_len, sb_q[$].len);
        chk_val("src_at_req", cur_src, sb_q[$].src);
        s = sb_q[$].src;
        n = 0;
        while (pub_app_data_req && n < 3000) begin
            tick();
            n++;
            if (corrupt && n == 1) begin
                src_data[s*DW +: DW] = ~src_data[s*DW +: DW];
                src_len[s*8 +: 8]    = 8'd5;
                src_valid[s]         = 1'b0;
            end
        end
        chk_val("req_cycles", n, grant_delay);
        n = 0;
        while (!pub_app_data_rel && n < 50) begin tick(); n++; end
        chk_val("grant_to_rel", n, HOLD);
        src_valid = '0;
        wait_idle();
    endtask

    task automatic chk_reset_outputs();
        chk_val("rst_req", pub_app_data_req, 0);
        chk_val("rst_rel", pub_app_data_rel, 0);
        chk_val("rst_ack", src_ack, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_cur_src", cur_src, 0);
        chk_val("rst_len", pub_app_data_len, 0);
        chk_val("rst_data", pub_app_data, 0);
    endtask

    initial begin
        int   n;
        int   base;
        bit   seen_rel;
        bit   seen_req_low;
        bit   seen_busy_low;
        exp_t e0;

        rst_n = 1'b0;
        src_valid = '0;
        src_data = '0;
        src_len = '0;
        pub_app_data_grant = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_val("idle_after_reset", busy, 0);

        // Single source, length 26, grant 3 cycles after req
        stage(0, 26, 26);
        run_handshake(0);

        // All sources pending: 0,1,2,3,0 with exact interval spacing
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        have_rel = 0;
        tick();
        chk_val("sb_empty_before_rr", sb_q.size(), 0);
        for (int i = 0; i < NS; i++) stage(i, 10 * (i + 1), 10 * (i + 1));
        e0 = sb_q[0];
        sb_q.push_back(e0);
        grant_delay = 1;
        spacing_chk = 1;
        base = rel_count;
        n = 0;
        while (rel_count < base + 5 && n < 300) begin tick(); n++; end
        src_valid = '0;
        spacing_chk = 0;
        chk_val("round_rels", rel_count - base, 5);
        wait_idle();
        grant_delay = 3;

        // Length clamp and zero-length pass-through
        stage(1, 200, 64);
        run_handshake(0);
        stage(3, 65, 64);
        run_handshake(0);
        stage(2, 0, 0);
        run_handshake(0);

        // Snapshot: corrupt source data and drop valid while in REQ
        stage(0, 30, 30);
        run_handshake(1);

        // Reset during HOLD abandons the message
        src_data[3*DW +: DW] = rand_data();
        src_len[3*8 +: 8] = 8'd17;
        src_valid = 4'b1000;
        n = 0;
        while (!pub_app_data_req && n < 20) begin tick(); n++; end
        n = 0;
        while (pub_app_data_req && n < 50) begin tick(); n++; end
        tick();
        chk_val("in_hold_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        src_valid = '0;
        stage(2, 44, 44);
        repeat (3) tick();
        rst_n = 1'b1;
        run_handshake(0);

        // Grant stuck low: req held, no rel
        grant_en = 0;
        stage(1, 10, 10);
        n = 0;
        while (!pub_app_data_req && n < 20) begin tick(); n++; end
        seen_rel = 0;
        seen_req_low = 0;
        seen_busy_low = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            seen_rel |= pub_app_data_rel;
            seen_req_low |= !pub_app_data_req;
            seen_busy_low |= !busy;
        end
        chk_val("stuck_no_rel", seen_rel, 0);
        chk_val("stuck_req_high", seen_req_low, 0);
        chk_val("stuck_busy_high", seen_busy_low, 0);
        grant_en = 1;
        wait_rel();
        src_valid = '0;
        grant_en = 0;

        // Stray grant in GAP is ignored, including for the next request
        tick();
        pub_app_data_grant = 1'b1;
        seen_rel = 0;
        seen_req_low = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_rel |= pub_app_data_rel;
            seen_req_low &= !pub_app_data_req;
        end
        pub_app_data_grant = 1'b0;
        chk_val("gap_stray_no_rel", seen_rel, 0);
        chk_val("gap_stray_no_req", seen_req_low, 1);
        stage(0, 12, 12);
        n = 0;
        while (!pub_app_data_req && n < 50) begin tick(); n++; end
        chk_val("req_after_gap", pub_app_data_req, 1);
        repeat (5) tick();
        chk_val("req_waits_grant", pub_app_data_req, 1);
        grant_en = 1;
        wait_rel();
        src_valid = '0;
        wait_idle();

        chk_val("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
